// File: rtl/seq_feeder.sv
// rtl/seq_feeder.sv - Host-loaded S/T symbol buffers streamed to a systolic alignment array.
// Optional result-wait watchdog enabled by defining FEEDER_TIMEOUT_EN.
module seq_feeder #(
    parameter int          S_DEPTH   = 64,
    parameter int          T_DEPTH   = 256,
    parameter logic [15:0] TO_CYCLES = 16'd4096
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        wr_en_i,
    input  logic        wr_sel_i,
    input  logic [2:0]  wr_data_i,
    input  logic        start_i,
    input  logic        core_valid_i,
    input  logic        core_busy_i,
    input  logic        t_valid_in_i,
    input  logic [15:0] max_i,
    output logic [2:0]  s_o,
    output logic [2:0]  t_o,
    output logic [15:0] s_len_o,
    output logic [15:0] t_len_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] score_o,
    output logic        err_o
);

    localparam int          SAW   = (S_DEPTH > 1) ? $clog2(S_DEPTH) : 1;
    localparam int          TAW   = (T_DEPTH > 1) ? $clog2(T_DEPTH) : 1;
    localparam logic [15:0] S_MAX = 16'(S_DEPTH);
    localparam logic [15:0] T_MAX = 16'(T_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND_S, SEND_T, WAIT_RES} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_s_mem [S_DEPTH];
    logic [2:0]  r_t_mem [T_DEPTH];
    logic [15:0] r_s_ptr;
    logic [15:0] r_t_ptr;
    logic [15:0] r_idx;
    logic [15:0] r_score;
    logic        r_done;
    logic        r_err;

    logic w_idle;
    logic w_len_ok;
    logic w_start_ok;
    logic w_start_bad;
    logic w_wr_ok;
    logic w_s_full;
    logic w_t_full;
    logic w_s_wr;
    logic w_t_wr;
    logic w_wr_drop;
    logic w_s_last;
    logic w_t_last;
    logic w_capture;
    logic w_timeout;

    assign w_idle      = (r_state == IDLE);
    assign w_len_ok    = (r_s_ptr != 16'd0) && (r_s_ptr <= S_MAX) &&
                         (r_t_ptr != 16'd0) && (r_t_ptr <= T_MAX);
    assign w_start_ok  = w_idle && start_i && w_len_ok && !core_busy_i;
    assign w_start_bad = w_idle && start_i && !w_start_ok;
    // An accepted start freezes the lengths, so a same-cycle write is discarded.
    assign w_wr_ok     = w_idle && wr_en_i && !w_start_ok;
    assign w_s_full    = (r_s_ptr >= S_MAX);
    assign w_t_full    = (r_t_ptr >= T_MAX);
    assign w_s_wr      = w_wr_ok && !wr_sel_i && !w_s_full;
    assign w_t_wr      = w_wr_ok &&  wr_sel_i && !w_t_full;
    assign w_wr_drop   = w_wr_ok && (wr_sel_i ? w_t_full : w_s_full);
    assign w_s_last    = (r_idx == r_s_ptr - 16'd1);
    assign w_t_last    = (r_idx == r_t_ptr - 16'd1);
    assign w_capture   = (r_state == WAIT_RES) && core_valid_i;

`ifdef FEEDER_TIMEOUT_EN
    logic [15:0] r_wdog;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_wdog <= 16'd0;
        end else if ((r_state == WAIT_RES) && !core_valid_i) begin
            r_wdog <= r_wdog + 16'd1;
        end else begin
            r_wdog <= 16'd0;
        end
    end

    assign w_timeout = (r_state == WAIT_RES) && !core_valid_i && (r_wdog == TO_CYCLES - 16'd1);
`else
    logic w_unused_to;
    assign w_unused_to = ^TO_CYCLES;
    assign w_timeout   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        s_o    = 3'd0;
        t_o    = 3'd0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_next = SEND_S;
            end
            SEND_S: begin
                s_o = r_s_mem[r_idx[SAW-1:0]];
                if (w_s_last) w_next = SEND_T;
            end
            SEND_T: begin
                if (t_valid_in_i) begin
                    t_o = r_t_mem[r_idx[TAW-1:0]];
                    if (w_t_last) w_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (w_capture || w_timeout) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_s_wr) r_s_mem[r_s_ptr[SAW-1:0]] <= wr_data_i;
        if (w_t_wr) r_t_mem[r_t_ptr[TAW-1:0]] <= wr_data_i;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_s_ptr <= 16'd0;
            r_t_ptr <= 16'd0;
            r_idx   <= 16'd0;
            r_score <= 16'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= w_capture;
            if (w_capture) r_score <= max_i;

            if (w_capture || w_timeout) begin
                r_s_ptr <= 16'd0;
                r_t_ptr <= 16'd0;
            end else begin
                if (w_s_wr) r_s_ptr <= r_s_ptr + 16'd1;
                if (w_t_wr) r_t_ptr <= r_t_ptr + 16'd1;
            end

            // One read index serves both streams; it rewinds when S finishes.
            case (r_state)
                SEND_S:  r_idx <= w_s_last ? 16'd0 : r_idx + 16'd1;
                SEND_T:  if (t_valid_in_i) r_idx <= w_t_last ? 16'd0 : r_idx + 16'd1;
                default: r_idx <= 16'd0;
            endcase

            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_start_bad || w_wr_drop || w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign s_len_o = r_s_ptr;
    assign t_len_o = r_t_ptr;
    assign busy_o  = (r_state != IDLE);
    assign done_o  = r_done;
    assign score_o = r_score;
    assign err_o   = r_err;

endmodule

// File: tb/tb_seq_feeder.sv
// tb/tb_seq_feeder.sv - Randomized scoreboard bench for seq_feeder.
// Define FEEDER_TIMEOUT_EN to also exercise the result-wait watchdog.
`timescale 1ns/1ps
module tb_seq_feeder;
    localparam int S_DEPTH = 64;
    localparam int T_DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        wr_en_i = 1'b0;
    logic        wr_sel_i = 1'b0;
    logic [2:0]  wr_data_i = 3'd0;
    logic        start_i = 1'b0;
    logic        core_valid_i = 1'b0;
    logic        core_busy_i = 1'b0;
    logic        t_valid_in_i = 1'b0;
    logic [15:0] max_i = 16'd0;
    logic [2:0]  s_o;
    logic [2:0]  t_o;
    logic [15:0] s_len_o;
    logic [15:0] t_len_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] score_o;
    logic        err_o;

    seq_feeder #(.S_DEPTH(S_DEPTH), .T_DEPTH(T_DEPTH), .TO_CYCLES(16'd10)) dut (
        .clk(clk), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i),
        .wr_data_i(wr_data_i), .start_i(start_i), .core_valid_i(core_valid_i),
        .core_busy_i(core_busy_i), .t_valid_in_i(t_valid_in_i), .max_i(max_i),
        .s_o(s_o), .t_o(t_o), .s_len_o(s_len_o), .t_len_o(t_len_o), .busy_o(busy_o),
        .done_o(done_o), .score_o(score_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [2:0]  s_model[$];
    logic [2:0]  t_model[$];
    logic [2:0]  exp_s[$];
    logic [2:0]  exp_t[$];
    logic [15:0] exp_score[$];
    logic        exp_err = 1'b0;
    logic [15:0] last_score = 16'd0;
    int          t_cnt = 0;
    int          t_base = 0;
    int          done_cnt = 0;
    int          tv_mode = 0;
    int          lowc = 0;
    logic        prev_s = 1'b0;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops scoreboard queues whenever the DUT presents a symbol or a result.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (prev_s && exp_s.size() != 0) check("s_gap", 32'(s_o != 3'd0), 1);
            if (prev_s && s_o == 3'd0 && exp_s.size() == 0 && exp_t.size() != 0 && t_valid_in_i)
                check("s_to_t", 32'(t_o != 3'd0), 1);
            if (s_o != 3'd0) begin
                if (exp_s.size() == 0) check("s_unexpected", 32'(s_o), 0);
                else check("s_sym", 32'(s_o), 32'(exp_s.pop_front()));
            end
            if (busy_o && !t_valid_in_i) check("t_bubble", 32'(t_o), 0);
            if (t_o != 3'd0) begin
                if (exp_t.size() == 0) check("t_unexpected", 32'(t_o), 0);
                else check("t_sym", 32'(t_o), 32'(exp_t.pop_front()));
                t_cnt++;
            end
            if (done_o) begin
                check("done_width", 32'(prev_done), 0);
                if (exp_score.size() == 0) check("done_unexpected", 32'(done_o), 0);
                else check("score", 32'(score_o), 32'(exp_score.pop_front()));
                done_cnt++;
            end
            prev_s    = (s_o != 3'd0);
            prev_done = done_o;
        end else begin
            prev_s    = 1'b0;
            prev_done = 1'b0;
        end
    end

    // t_valid_in_i pattern: 0 = always high, 1 = random, 2 = two-cycle stall after T[1].
    always @(posedge clk) begin
        #1;
        case (tv_mode)
            0: t_valid_in_i = 1'b1;
            1: t_valid_in_i = 1'($urandom_range(1, 0));
            default: begin
                if ((t_cnt - t_base) == 2 && lowc < 2) begin
                    t_valid_in_i = 1'b0;
                    lowc++;
                end else begin
                    t_valid_in_i = 1'b1;
                end
            end
        endcase
        if (tv_mode != 2) lowc = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wr1(input logic sel, input logic [2:0] d);
        tick();
        wr_en_i = 1'b1; wr_sel_i = sel; wr_data_i = d;
        if (!sel) begin
            if (s_model.size() < S_DEPTH) s_model.push_back(d); else exp_err = 1'b1;
        end else begin
            if (t_model.size() < T_DEPTH) t_model.push_back(d); else exp_err = 1'b1;
        end
    endtask

    task automatic wr_end();
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic load_rand(input int sl, input int tl);
        for (int i = 0; i < sl; i++) wr1(1'b0, 3'($urandom_range(4, 1)));
        for (int i = 0; i < tl; i++) wr1(1'b1, 3'($urandom_range(4, 1)));
        wr_end();
    endtask

    task automatic do_start();
        logic ok;
        ok = (s_model.size() >= 1) && (t_model.size() >= 1) && !core_busy_i;
        settle();
        check("s_len", 32'(s_len_o), 32'(s_model.size()));
        check("t_len", 32'(t_len_o), 32'(t_model.size()));
        tick();
        start_i = 1'b1;
        if (ok) begin
            foreach (s_model[i]) exp_s.push_back(s_model[i]);
            foreach (t_model[i]) exp_t.push_back(t_model[i]);
            t_base  = t_cnt;
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        tick();
        start_i = 1'b0;
        @(negedge clk);
        check("start_busy", 32'(busy_o), 32'(ok));
        if (ok) check("first_s", 32'(s_o), 32'(s_model[0]));
        check("start_err", 32'(err_o), 32'(exp_err));
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_t.size() != 0 && b < 3000) begin
            settle();
            b++;
        end
        check("t_drain", 32'(exp_t.size()), 0);
        check("s_drain", 32'(exp_s.size()), 0);
    endtask

    task automatic finish_align(input logic [15:0] score);
        int b;
        int d0;
        int n;
        drain();
        tick();
        wr_en_i = 1'b1; wr_sel_i = 1'($urandom_range(1, 0)); wr_data_i = 3'd2; start_i = 1'b1;
        @(negedge clk);
        check("wait_busy", 32'(busy_o), 1);
        check("wait_slen_held", 32'(s_len_o), 32'(s_model.size()));
        check("wait_err", 32'(err_o), 32'(exp_err));
        n = $urandom_range(3, 0);
        for (int i = 0; i < n; i++) begin
            tick();
            wr_en_i = 1'b0; start_i = 1'b0;
            @(negedge clk);
            check("wait_busy_hold", 32'(busy_o), 1);
        end
        tick();
        wr_en_i = 1'b0; start_i = 1'b0;
        core_valid_i = 1'b1; max_i = score;
        exp_score.push_back(score);
        last_score = score;
        d0 = done_cnt;
        tick();
        core_valid_i = 1'b0; max_i = 16'($urandom);
        b = 0;
        while (done_cnt == d0 && b < 10) begin
            settle();
            b++;
        end
        check("done_seen", 32'(done_cnt - d0), 1);
        check("done_latency", 32'(b), 1);
        check("end_busy", 32'(busy_o), 0);
        check("end_slen", 32'(s_len_o), 0);
        check("end_tlen", 32'(t_len_o), 0);
        check("end_err", 32'(err_o), 32'(exp_err));
        s_model.delete();
        t_model.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation limit reached with %0d vectors", n_vec);
        $fatal(1);
    end

    initial begin
        int d0;
        int b;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_score", 32'(score_o), 0);
        check("rst_s", 32'(s_o), 0);
        check("rst_t", 32'(t_o), 0);
        check("rst_slen", 32'(s_len_o), 0);
        #1 reset_i = 1'b0;

        // Directed: S=1,2,3 T=4,3,2,1, stray core_valid during SEND_S, result 37.
        tv_mode = 0;
        wr1(1'b0, 3'd1); wr1(1'b0, 3'd2); wr1(1'b0, 3'd3);
        wr1(1'b1, 3'd4); wr1(1'b1, 3'd3); wr1(1'b1, 3'd2); wr1(1'b1, 3'd1);
        wr_end();
        do_start();
        core_valid_i = 1'b1; max_i = 16'd999;
        tick();
        core_valid_i = 1'b0;
        finish_align(16'd37);
        check("score_held", 32'(score_o), 37);

        // Stall two cycles after T[1].
        tv_mode = 2;
        load_rand(2, 5);
        do_start();
        finish_align(16'($urandom));

        // Start with no S symbols, then a valid start clears err.
        tv_mode = 1;
        load_rand(0, 2);
        do_start();
        load_rand(3, 0);
        do_start();
        finish_align(16'($urandom));

        // Start while the array is busy.
        load_rand(2, 2);
        core_busy_i = 1'b1;
        do_start();
        core_busy_i = 1'b0;
        do_start();
        finish_align(16'($urandom));

        // Buffer overflow: 65 S and 257 T writes, then a full-size alignment.
        load_rand(S_DEPTH + 1, T_DEPTH + 1);
        settle();
        check("ovf_err", 32'(err_o), 1);
        check("ovf_busy", 32'(busy_o), 0);
        check("ovf_slen", 32'(s_len_o), S_DEPTH);
        check("ovf_tlen", 32'(t_len_o), T_DEPTH);
        do_start();
        finish_align(16'hFFFF);

        for (int k = 0; k < 8; k++) begin
            load_rand($urandom_range(10, 1), $urandom_range(16, 1));
            do_start();
            finish_align(16'($urandom));
        end

        // Reset in the middle of SEND_T.
        tv_mode = 0;
        load_rand(3, 6);
        do_start();
        b = 0;
        while ((t_cnt - t_base) < 2 && b < 100) begin
            settle();
            b++;
        end
        check("reach_send_t", 32'((t_cnt - t_base) >= 2), 1);
        reset_i = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_s", 32'(s_o), 0);
        check("mid_rst_t", 32'(t_o), 0);
        check("mid_rst_score", 32'(score_o), 0);
        check("mid_rst_err", 32'(err_o), 0);
        check("mid_rst_done", 32'(done_o), 0);
        check("mid_rst_slen", 32'(s_len_o), 0);
        check("mid_rst_tlen", 32'(t_len_o), 0);
        exp_s.delete(); exp_t.delete(); exp_score.delete();
        s_model.delete(); t_model.delete();
        exp_err = 1'b0; last_score = 16'd0;
        repeat (2) @(negedge clk);
        #1 reset_i = 1'b0;
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("no_done_after_rst", 32'(done_cnt), 32'(d0));
        check("idle_after_rst", 32'(busy_o), 0);

`ifdef FEEDER_TIMEOUT_EN
        // Watchdog: no core_valid, ten WAIT_RES cycles then IDLE with err and no done.
        load_rand(2, 3);
        do_start();
        drain();
        d0 = done_cnt;
        b = 0;
        while (b < 40) begin
            settle();
            if (!busy_o) break;
            b++;
        end
        check("to_cycles", 32'(b), 10);
        check("to_err", 32'(err_o), 1);
        check("to_no_done", 32'(done_cnt), 32'(d0));
        check("to_score_kept", 32'(score_o), 32'(last_score));
        s_model.delete(); t_model.delete();
`endif

        repeat (3) @(negedge clk);
        check("final_exp_score_empty", 32'(exp_score.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_feeder.md
SEQ_FEEDER -- requirements
Module: seq_feeder

Interface
REQ-001 Parameter S_DEPTH, default 64: capacity of the S symbol buffer (query sequence).
REQ-002 Parameter T_DEPTH, default 256: capacity of the T symbol buffer (database sequence).
REQ-003 Parameter TO_CYCLES, default 16'd4096: watchdog limit for the result wait.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 wr_en_i  input  1  host symbol write strobe.
REQ-007 wr_sel_i  input  1  0 = write S buffer, 1 = write T buffer.
REQ-008 wr_data_i  input  3  symbol to write; 3'd1..3'd4 = A/C/G/T.
REQ-009 start_i  input  1  single-cycle pulse that launches one alignment.
REQ-010 core_valid_i  input  1  score valid from the array.
REQ-011 core_busy_i  input  1  array busy.
REQ-012 t_valid_in_i  input  1  array can accept a T symbol this cycle.
REQ-013 max_i  input  16  array maximum score.
REQ-014 s_o / t_o  output  3 each  symbol streams to the array; 3'd0 = bubble.
REQ-015 s_len_o / t_len_o  output  16 each  lengths presented to the array.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 done_o  output  1  one-cycle pulse, score_o valid.
REQ-018 score_o  output  16  captured score.
REQ-019 err_o  output  1  sticky error flag, cleared by the next accepted start.

Function
REQ-020 Writes are accepted only in IDLE; each write stores at the selected buffer's pointer, then increments it; writes at pointer == depth are dropped and set err_o.
REQ-021 s_len_o/t_len_o equal the S/T write pointers; they are held constant from start acceptance until return to IDLE.
REQ-022 start_i is accepted in IDLE only when 1 <= s_len_o <= S_DEPTH, 1 <= t_len_o <= T_DEPTH, and core_busy_i is low; otherwise it is ignored and, if in IDLE, sets err_o.
REQ-023 FSM states: IDLE, SEND_S, SEND_T, WAIT_RES; accepted start -> SEND_S on the next edge.
REQ-024 SEND_S drives S[0..s_len-1] on s_o over consecutive cycles, one per cycle, with no gaps; the cycle after S[s_len-1] enters SEND_T.
REQ-025 SEND_T drives T[k] on t_o only in cycles with t_valid_in_i high and advances k only then; in other cycles it drives 3'd0 and holds k.
REQ-026 After T[t_len-1] is sent, the FSM enters WAIT_RES; s_o/t_o are 3'd0 in every state except their own send state.
REQ-027 In WAIT_RES, the first cycle with core_valid_i high captures max_i into score_o, pulses done_o on the next cycle, clears both write pointers, and returns to IDLE.
REQ-028 score_o holds its value until the next capture; start_i and wr_en_i are ignored outside IDLE.
REQ-029 core_valid_i outside WAIT_RES is ignored.

Reset
REQ-030 While reset_i is high: state = IDLE, pointers = 0, s_o = t_o = 3'd0, score_o = 0, done_o = busy_o = err_o = 0, watchdog = 0.
REQ-031 Reset asserted mid-transfer abandons the alignment immediately; no done_o is produced afterward.

Configuration
REQ-032 With FEEDER_TIMEOUT_EN defined, a 16-bit counter runs in WAIT_RES; reaching TO_CYCLES sets err_o and returns to IDLE without done_o, leaving score_o unchanged.
REQ-033 Without FEEDER_TIMEOUT_EN, there is no counter and WAIT_RES waits indefinitely.

Verification
REQ-034 Write S = 1,2,3; T = 4,3,2,1, then start with t_valid_in_i held high -> s_o = 1,2,3 on three consecutive cycles, then t_o = 4,3,2,1, then busy_o stays high until core_valid_i.
REQ-035 During SEND_T, hold t_valid_in_i low for two cycles after T[1] -> t_o = 0 for those cycles, T[2] is sent on re-assertion, and no symbol is skipped or repeated.
REQ-036 In WAIT_RES, set core_valid_i = 1 with max_i = 16'd37 -> score_o = 37, done_o high for exactly one cycle, then IDLE with pointers = 0.
REQ-037 Start with s_len = 0, or with 65 S writes (S_DEPTH = 64) -> err_o = 1 and the start is ignored or the 65th write is dropped; busy_o stays 0.
REQ-038 Assert reset_i during SEND_T -> all outputs reach reset values immediately, and no done_o follows.
REQ-039 With FEEDER_TIMEOUT_EN and TO_CYCLES = 16'd10, core_valid_i never high -> err_o = 1 after 10 cycles in WAIT_RES, then IDLE with no done_o.
